// File: rtl/wbqueue_drain.sv
// Write-back drain stage for the hybrid cache.
//
// Takes write requests from the head of the write-back queue and issues each one to
// the memory write port over a request/acknowledge handshake. If an acknowledge does
// not arrive in time, the request is re-issued up to MAXRETRY times and is then
// dropped. Idle status, sticky error status and a completed-write count go to the
// cache controller.
//
// Ports:
//   clk             clock; all logic on the rising edge
//   reset           synchronous, active-high
//   queue_out       queue head, packed {be, addr, data}
//   queue_not_empty queue head valid
//   queue_pop       one-cycle pop; the queue advances at the next edge
//   mem_wr          write request, held until acknowledged or timed out
//   mem_addr        registered write address
//   mem_wdata       registered write data
//   mem_be          registered byte enables
//   mem_ack         single-cycle acknowledge, only honoured while mem_wr=1
//   drain_idle      nothing in flight and queue empty
//   drain_error     sticky; set when an entry is dropped
//   write_count     acknowledged writes, wraps at 16 bits
module wbqueue_drain #(
  parameter int unsigned ADDRBITS    = 32,
  parameter int unsigned DATABITS    = 32,
  parameter int unsigned BEBITS      = DATABITS / 8,
  parameter int unsigned TIMEOUTBITS = 8,
  parameter int unsigned MAXRETRY    = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [BEBITS+ADDRBITS+DATABITS-1:0] queue_out,
  input  logic                                queue_not_empty,
  output logic                                queue_pop,
  output logic                                mem_wr,
  output logic [ADDRBITS-1:0]                 mem_addr,
  output logic [DATABITS-1:0]                 mem_wdata,
  output logic [BEBITS-1:0]                   mem_be,
  input  logic                                mem_ack,
  output logic                                drain_idle,
  output logic                                drain_error,
  output logic [15:0]                         write_count
);

  localparam int unsigned RetryBits = (MAXRETRY > 0) ? $clog2(MAXRETRY + 1) : 1;

  // The counter holds k in the k-th ISSUE cycle (from 0), so a request that sees no
  // ack while the counter is at this value has spent 2**TIMEOUTBITS-1 cycles in ISSUE.
  localparam logic [TIMEOUTBITS-1:0] TmoLast =
      TIMEOUTBITS'((64'd1 << TIMEOUTBITS) - 64'd2);
  localparam logic [RetryBits-1:0] RetryMax = RetryBits'(MAXRETRY);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRetry
  } state_e;

  state_e                 state_q;
  logic [TIMEOUTBITS-1:0] tmo_q;
  logic [RetryBits-1:0]   retry_q;

  always_comb begin
    queue_pop  = ((state_q == StIdle) || ((state_q == StIssue) && mem_ack)) &&
                 queue_not_empty && !reset;
    drain_idle = (state_q == StIdle) && !queue_not_empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      tmo_q       <= '0;
      retry_q     <= '0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      drain_error <= 1'b0;
      write_count <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (queue_not_empty) begin
            {mem_be, mem_addr, mem_wdata} <= queue_out;
            mem_wr  <= 1'b1;
            tmo_q   <= '0;
            retry_q <= '0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          // An ack in the timeout cycle still counts as success.
          if (mem_ack) begin
            write_count <= write_count + 16'd1;
            tmo_q       <= '0;
            retry_q     <= '0;
            if (queue_not_empty) begin
              // Back-to-back: the head was popped this cycle, mem_wr stays high.
              {mem_be, mem_addr, mem_wdata} <= queue_out;
            end else begin
              mem_wr  <= 1'b0;
              state_q <= StIdle;
            end
          end else if (tmo_q == TmoLast) begin
            tmo_q  <= '0;
            mem_wr <= 1'b0;
            if (retry_q < RetryMax) begin
              retry_q <= retry_q + RetryBits'(1);
              state_q <= StRetry;
            end else begin
              retry_q     <= '0;
              drain_error <= 1'b1;
              state_q     <= StIdle;
            end
          end else begin
            tmo_q <= tmo_q + TIMEOUTBITS'(1);
          end
        end
        StRetry: begin
          // One cycle with mem_wr low, request fields held.
          mem_wr  <= 1'b1;
          state_q <= StIssue;
        end
        default: begin
          mem_wr  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbqueue_drain.sv
// Directed bench for wbqueue_drain with a queue model feeding the head and a
// scoreboard of expected memory writes checked whenever a write is acknowledged.
module tb_wbqueue_drain;

  localparam int W = 68;

  logic          clk;
  logic          reset;
  logic [W-1:0]  queue_out;
  logic          queue_not_empty;
  logic          queue_pop;
  logic          mem_wr;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic          drain_idle;
  logic          drain_error;
  logic [15:0]   write_count;

  wbqueue_drain #(
    .ADDRBITS   (32),
    .DATABITS   (32),
    .BEBITS     (4),
    .TIMEOUTBITS(3),
    .MAXRETRY   (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .queue_out      (queue_out),
    .queue_not_empty(queue_not_empty),
    .queue_pop      (queue_pop),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_ack        (mem_ack),
    .drain_idle     (drain_idle),
    .drain_error    (drain_error),
    .write_count    (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pop_cnt = 0;
  int wr_cyc = 0;
  int rise_cnt = 0;
  logic last_pop = 1'b0;
  logic prev_wr = 1'b0;
  logic prev_ack = 1'b0;
  logic prev_reset = 1'b1;
  logic [W-1:0] prev_bus = '0;
  logic [W-1:0] fifo[$];
  logic [W-1:0] exp_q[$];

  task automatic pass();
    n_cmp++;
  endtask

  task automatic fail(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: samples 3 time units after the falling edge, once inputs are settled.
  always @(negedge clk) begin
    logic [W-1:0] bus;
    logic [W-1:0] e;
    #3;
    bus = {mem_be, mem_addr, mem_wdata};
    last_pop = queue_pop;
    if (queue_pop) pop_cnt++;
    if (mem_wr) wr_cyc++;
    if (mem_wr && !prev_wr) rise_cnt++;
    if (mem_wr && prev_wr && !prev_ack && !prev_reset) begin
      if (bus !== prev_bus) fail("hold_stable", 72'(bus), 72'(prev_bus));
      else pass();
    end
    if (mem_wr && mem_ack && !reset) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 'x;
      if (bus !== e) fail("sb_write", 72'(bus), 72'(e));
      else pass();
    end
    prev_wr    = mem_wr;
    prev_ack   = mem_ack;
    prev_reset = reset;
    prev_bus   = bus;
  end

  // Advance one clock; apply a pop seen before the edge, then refresh the head.
  task automatic step();
    logic popped;
    @(posedge clk);
    popped = last_pop;
    @(negedge clk);
    if (popped) begin
      if (fifo.size() == 0) fail("pop_nonempty", 72'(fifo.size()), 72'(1));
      else pass();
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    queue_not_empty = (fifo.size() != 0);
    queue_out = (fifo.size() != 0) ? fifo[0] : '0;
    #1;
  endtask

  task automatic push(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d,
                      input bit expect_wr);
    fifo.push_back({be, a, d});
    if (expect_wr) exp_q.push_back({be, a, d});
    queue_not_empty = 1'b1;
    queue_out = fifo[0];
  endtask

  initial begin
    int base_pop;
    int base_wr;
    int base_rise;
    logic [W-1:0] saved;

    reset = 1'b1;
    mem_ack = 1'b0;
    queue_not_empty = 1'b0;
    queue_out = '0;

    // Reset values
    step();
    step();
    if (mem_wr !== 1'b0) fail("rst_mem_wr", 72'(mem_wr), 72'(0)); else pass();
    if ({mem_be, mem_addr, mem_wdata} !== 68'd0)
      fail("rst_mem_bus", 72'({mem_be, mem_addr, mem_wdata}), 72'(0));
    else pass();
    if (write_count !== 16'd0) fail("rst_write_count", 72'(write_count), 72'(0)); else pass();
    if (drain_error !== 1'b0) fail("rst_drain_error", 72'(drain_error), 72'(0)); else pass();
    if (queue_pop !== 1'b0) fail("rst_queue_pop", 72'(queue_pop), 72'(0)); else pass();
    if (drain_idle !== 1'b1) fail("rst_drain_idle", 72'(drain_idle), 72'(1)); else pass();
    reset = 1'b0;

    // Single entry, ack two cycles after mem_wr rises
    base_pop = pop_cnt;
    push(4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
    #1;
    if (queue_pop !== 1'b1) fail("t1_pop_now", 72'(queue_pop), 72'(1)); else pass();
    if (mem_wr !== 1'b0) fail("t1_no_wr_yet", 72'(mem_wr), 72'(0)); else pass();
    step();
    if (mem_wr !== 1'b1) fail("t1_wr_rise", 72'(mem_wr), 72'(1)); else pass();
    if ({mem_be, mem_addr, mem_wdata} !== {4'hF, 32'h0000_1000, 32'hDEAD_BEEF})
      fail("t1_bus", 72'({mem_be, mem_addr, mem_wdata}),
           72'({4'hF, 32'h0000_1000, 32'hDEAD_BEEF}));
    else pass();
    if (queue_pop !== 1'b0) fail("t1_pop_once", 72'(queue_pop), 72'(0)); else pass();
    if (drain_idle !== 1'b0) fail("t1_not_idle", 72'(drain_idle), 72'(0)); else pass();
    step();
    mem_ack = 1'b1;
    if (mem_wr !== 1'b1) fail("t1_wr_held", 72'(mem_wr), 72'(1)); else pass();
    step();
    mem_ack = 1'b0;
    if (mem_wr !== 1'b0) fail("t1_wr_done", 72'(mem_wr), 72'(0)); else pass();
    if (write_count !== 16'd1) fail("t1_count", 72'(write_count), 72'(1)); else pass();
    if (drain_idle !== 1'b1) fail("t1_idle", 72'(drain_idle), 72'(1)); else pass();
    if (pop_cnt - base_pop !== 1) fail("t1_pops", 72'(pop_cnt - base_pop), 72'(1)); else pass();

    // Eight entries, ack tied high
    base_pop = pop_cnt;
    base_wr = wr_cyc;
    for (int i = 0; i < 8; i++)
      push(4'(i + 1), 32'h2000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 1'b1);
    mem_ack = 1'b1;
    repeat (10) step();
    mem_ack = 1'b0;
    if (wr_cyc - base_wr !== 8) fail("t2_wr_cycles", 72'(wr_cyc - base_wr), 72'(8)); else pass();
    if (pop_cnt - base_pop !== 8) fail("t2_pops", 72'(pop_cnt - base_pop), 72'(8)); else pass();
    if (write_count !== 16'd9) fail("t2_count", 72'(write_count), 72'(9)); else pass();
    if (mem_wr !== 1'b0) fail("t2_wr_low", 72'(mem_wr), 72'(0)); else pass();

    // One timeout, then ack on the re-issue
    push(4'h3, 32'h0000_3000, 32'h1234_5678, 1'b1);
    step();
    if (mem_wr !== 1'b1) fail("t3_wr_rise", 72'(mem_wr), 72'(1)); else pass();
    saved = {mem_be, mem_addr, mem_wdata};
    repeat (6) step();
    if (mem_wr !== 1'b1) fail("t3_wr_7th", 72'(mem_wr), 72'(1)); else pass();
    step();
    if (mem_wr !== 1'b0) fail("t3_retry_gap", 72'(mem_wr), 72'(0)); else pass();
    if ({mem_be, mem_addr, mem_wdata} !== {4'h3, 32'h0000_3000, 32'h1234_5678})
      fail("t3_bus_in_gap", 72'({mem_be, mem_addr, mem_wdata}),
           72'({4'h3, 32'h0000_3000, 32'h1234_5678}));
    else pass();
    step();
    if (mem_wr !== 1'b1) fail("t3_reissue", 72'(mem_wr), 72'(1)); else pass();
    if ({mem_be, mem_addr, mem_wdata} !== saved)
      fail("t3_same_bus", 72'({mem_be, mem_addr, mem_wdata}), 72'(saved));
    else pass();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    if (write_count !== 16'd10) fail("t3_count", 72'(write_count), 72'(10)); else pass();
    if (drain_error !== 1'b0) fail("t3_no_error", 72'(drain_error), 72'(0)); else pass();
    if (mem_wr !== 1'b0) fail("t3_wr_low", 72'(mem_wr), 72'(0)); else pass();

    // Never acked: 4 attempts, drop, next entry goes out normally
    push(4'h1, 32'h0000_4000, 32'h0BAD_0BAD, 1'b0);
    push(4'h2, 32'h0000_5000, 32'h5555_AAAA, 1'b1);
    base_rise = rise_cnt;
    repeat (31) step();
    if (drain_error !== 1'b0) fail("t4_err_late", 72'(drain_error), 72'(0)); else pass();
    if (mem_wr !== 1'b1) fail("t4_last_attempt", 72'(mem_wr), 72'(1)); else pass();
    step();
    if (drain_error !== 1'b1) fail("t4_error", 72'(drain_error), 72'(1)); else pass();
    if (write_count !== 16'd10) fail("t4_count_kept", 72'(write_count), 72'(10)); else pass();
    if (mem_wr !== 1'b0) fail("t4_dropped", 72'(mem_wr), 72'(0)); else pass();
    if (rise_cnt - base_rise !== 4)
      fail("t4_attempts", 72'(rise_cnt - base_rise), 72'(4));
    else pass();
    if (queue_pop !== 1'b1) fail("t4_next_pop", 72'(queue_pop), 72'(1)); else pass();
    mem_ack = 1'b1;
    step();
    if ({mem_be, mem_addr, mem_wdata} !== {4'h2, 32'h0000_5000, 32'h5555_AAAA})
      fail("t4_next_bus", 72'({mem_be, mem_addr, mem_wdata}),
           72'({4'h2, 32'h0000_5000, 32'h5555_AAAA}));
    else pass();
    step();
    mem_ack = 1'b0;
    if (write_count !== 16'd11) fail("t4_next_count", 72'(write_count), 72'(11)); else pass();
    if (drain_error !== 1'b1) fail("t4_err_sticky", 72'(drain_error), 72'(1)); else pass();

    // Reset while a write is in flight
    push(4'h6, 32'h0000_6000, 32'h6666_6666, 1'b0);
    push(4'h7, 32'h0000_7000, 32'h7777_7777, 1'b1);
    push(4'h8, 32'h0000_8000, 32'h8888_8888, 1'b1);
    step();
    step();
    if (mem_wr !== 1'b1) fail("t5_in_flight", 72'(mem_wr), 72'(1)); else pass();
    reset = 1'b1;
    mem_ack = 1'b1;
    #1;
    if (queue_pop !== 1'b0) fail("t5_no_pop_in_reset", 72'(queue_pop), 72'(0)); else pass();
    base_pop = pop_cnt;
    step();
    reset = 1'b0;
    if (mem_wr !== 1'b0) fail("t5_wr_cleared", 72'(mem_wr), 72'(0)); else pass();
    if ({mem_be, mem_addr, mem_wdata} !== 68'd0)
      fail("t5_bus_cleared", 72'({mem_be, mem_addr, mem_wdata}), 72'(0));
    else pass();
    if (write_count !== 16'd0) fail("t5_count_cleared", 72'(write_count), 72'(0)); else pass();
    if (drain_error !== 1'b0) fail("t5_error_cleared", 72'(drain_error), 72'(0)); else pass();
    if (pop_cnt - base_pop !== 0)
      fail("t5_pops_in_reset", 72'(pop_cnt - base_pop), 72'(0));
    else pass();
    step();
    if ({mem_be, mem_addr, mem_wdata} !== {4'h7, 32'h0000_7000, 32'h7777_7777})
      fail("t5_resume_bus", 72'({mem_be, mem_addr, mem_wdata}),
           72'({4'h7, 32'h0000_7000, 32'h7777_7777}));
    else pass();
    step();
    step();
    mem_ack = 1'b0;
    if (write_count !== 16'd2) fail("t5_count", 72'(write_count), 72'(2)); else pass();
    if (drain_idle !== 1'b1) fail("t5_idle", 72'(drain_idle), 72'(1)); else pass();

    // write_count wrap
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 65535; i++) push(4'hF, 32'(i), ~32'(i), 1'b1);
    mem_ack = 1'b1;
    repeat (65537) step();
    if (write_count !== 16'hFFFF) fail("t6_count_max", 72'(write_count), 72'(16'hFFFF)); else pass();
    if (mem_wr !== 1'b0) fail("t6_wr_low", 72'(mem_wr), 72'(0)); else pass();
    push(4'hC, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
    repeat (3) step();
    mem_ack = 1'b0;
    if (write_count !== 16'h0000) fail("t6_count_wrap", 72'(write_count), 72'(0)); else pass();
    if (exp_q.size() !== 0) fail("sb_drained", 72'(exp_q.size()), 72'(0)); else pass();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
